// File: rtl/verilator_uart_tx_if.sv
// Byte handshake between the host-side stimulus and the UART transmitter.
// Latency: none, plain wires.
// Backpressure: the slave holds data_ready_o low when it cannot take a byte.
interface verilator_uart_tx_if;
  logic       data_valid_i;
  logic [7:0] data_i;
  logic       data_ready_o;

  modport master (
    output data_valid_i,
    output data_i,
    input  data_ready_o
  );

  modport slave (
    input  data_valid_i,
    input  data_i,
    output data_ready_o
  );
endinterface

// File: rtl/verilator_uart_tx.sv
// Simulation UART transmitter: FIFO-buffered bytes serialized as 8N1/8N2, LSB first.
// Latency: byte accepted at edge E0 into an idle, empty block drives the start bit at E1.
// Backpressure: data_ready_o drops while the FIFO holds FifoDepth bytes; set by registered state only.
module verilator_uart_tx #(
  parameter int BaudPeriodCycles = 1736,
  parameter int FifoDepth        = 16,
  parameter int StopBits         = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  verilator_uart_tx_if.slave               bus,
  output logic                             uart_tx_o,
  output logic                             busy_o,
  output logic [$clog2(FifoDepth+1)-1:0]   fifo_usage_o
);

  localparam int BaudW  = $clog2(BaudPeriodCycles);
  localparam int PtrW   = $clog2(FifoDepth);
  localparam int UsageW = $clog2(FifoDepth + 1);

  localparam logic [BaudW-1:0]  BaudLast  = BaudW'(BaudPeriodCycles - 1);
  localparam logic [UsageW-1:0] UsageFull = UsageW'(FifoDepth);
  localparam logic [2:0]        StopLast  = 3'(StopBits - 1);

  // Parameter sanity, caught at elaboration.
  if (BaudPeriodCycles < 2) begin : gen_chk_baud
    $error("BaudPeriodCycles must be >= 2");
  end
  if (StopBits != 1 && StopBits != 2) begin : gen_chk_stop
    $error("StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : gen_chk_depth
    $error("FifoDepth must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // FIFO storage and bookkeeping.
  logic [7:0]        mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [UsageW-1:0] usage_q;
  logic              ready;
  logic              push;
  logic              pop;
  logic              fifo_nonempty;
  logic [7:0]        head_dat;

  // Serializer state.
  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_end;

  // Ready depends only on reset and the registered fill level; a full FIFO refuses
  // a push even when a pop happens on the same edge.
  assign ready            = rst_ni && (usage_q != UsageFull);
  assign bus.data_ready_o = ready;
  assign push             = bus.data_valid_i && ready;
  assign fifo_nonempty    = (usage_q != '0);
  assign head_dat         = mem[rd_ptr_q];
  assign baud_end         = (baud_cnt_q == BaudLast);

  // Byte storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.data_i;
    end
  end

  // FIFO pointers and fill level; pointers wrap naturally at FifoDepth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      usage_q <= usage_q + UsageW'(push) - UsageW'(pop);
    end
  end

  // Serializer state register; reset abandons any frame and returns the line high.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state logic: each line level is held for one full baud period; the end of the
  // stop period chains straight into the next start bit when a byte is waiting.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_d    = head_dat;
          tx_d       = 1'b0;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == StopLast) begin
            bit_cnt_d = '0;
            if (fifo_nonempty) begin
              pop     = 1'b1;
              shift_d = head_dat;
              tx_d    = 1'b0;
              state_d = ST_START;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign uart_tx_o    = tx_q;
  assign busy_o       = (state_q != ST_IDLE) || fifo_nonempty;
  assign fifo_usage_o = usage_q;

  // The serial line must always be a known level once out of reset.
  a_tx_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(uart_tx_o));

endmodule

// File: tb/tb_verilator_uart_tx.sv
// Bench for verilator_uart_tx: two instances (1 and 2 stop bits) driven from one initial block.
// Latency: checks the line level after every edge against a waveform built from the byte list.
// Backpressure: expected fill level and ready are derived from accepted and started frame counts.
module tb_verilator_uart_tx;
  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam int UW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          tx1, tx2, busy1, busy2;
  logic [UW-1:0] use1, use2;

  verilator_uart_tx_if bus1 ();
  verilator_uart_tx_if bus2 ();

  verilator_uart_tx #(.BaudPeriodCycles(BAUD), .FifoDepth(DEPTH), .StopBits(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave),
    .uart_tx_o(tx1), .busy_o(busy1), .fifo_usage_o(use1)
  );

  verilator_uart_tx #(.BaudPeriodCycles(BAUD), .FifoDepth(DEPTH), .StopBits(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus2.slave),
    .uart_tx_o(tx2), .busy_o(busy2), .fifo_usage_o(use2)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q_in[$];

  function automatic logic sel_tx(input int w);
    return (w != 0) ? tx2 : tx1;
  endfunction
  function automatic logic sel_busy(input int w);
    return (w != 0) ? busy2 : busy1;
  endfunction
  function automatic logic sel_rdy(input int w);
    return (w != 0) ? bus2.data_ready_o : bus1.data_ready_o;
  endfunction
  function automatic int sel_use(input int w);
    return (w != 0) ? int'(use2) : int'(use1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic v, input logic [7:0] d);
    bus1.data_valid_i = (w == 0) && v;
    bus1.data_i       = d;
    bus2.data_valid_i = (w != 0) && v;
    bus2.data_i       = d;
  endtask

  // Pushes q_in into instance w holding valid, checking every cycle from the first
  // accepting edge (k=0) until the final stop bit, then the return to idle.
  task automatic run_stream(input int w, input string name);
    int   stop_bits = (w != 0) ? 2 : 1;
    int   flen      = (9 + stop_bits) * BAUD;
    int   n         = q_in.size();
    int   acc       = 0;
    int   k         = -1;
    int   exp_use   = 0;
    int   started;
    int   budget    = flen * (n + 2) + 16;
    bit   done      = 0;
    logic exp_line[$];
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < BAUD; c++) exp_line.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < BAUD; c++) exp_line.push_back(q_in[b][i]);
      for (int c = 0; c < stop_bits * BAUD; c++) exp_line.push_back(1'b1);
    end
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      logic v;
      bit   will_acc;
      v        = (acc < n);
      will_acc = v && (exp_use != DEPTH);
      drive(w, v, v ? q_in[acc] : 8'h00);
      step();
      if (k >= 0) k++;
      if (will_acc) begin
        if (k < 0) k = 0;
        acc++;
      end
      if (k >= 0) begin
        started = (k == 0) ? 0 : ((k - 1) / flen + 1);
        if (started > acc) started = acc;
        exp_use = acc - started;
        n_vec++;
        if (sel_use(w) !== exp_use) begin
          n_err++;
          $display("FAIL %s usage k=%0d got %0d want %0d", name, k, sel_use(w), exp_use);
        end
        n_vec++;
        if (sel_rdy(w) !== (exp_use != DEPTH)) begin
          n_err++;
          $display("FAIL %s ready k=%0d got %0b want %0b", name, k, sel_rdy(w), exp_use != DEPTH);
        end
        n_vec++;
        if (sel_busy(w) !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy k=%0d got %0b want 1", name, k, sel_busy(w));
        end
        n_vec++;
        if (sel_tx(w) !== ((k == 0) ? 1'b1 : exp_line[k-1])) begin
          n_err++;
          $display("FAIL %s line k=%0d got %0b want %0b", name, k, sel_tx(w),
                   (k == 0) ? 1'b1 : exp_line[k-1]);
        end
        if (k == flen * n) done = 1;
      end
    end
    drive(w, 1'b0, 8'h00);
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout got k=%0d want %0d", name, k, flen * n);
    end
    step();
    n_vec++;
    if (sel_busy(w) !== 1'b0 || sel_tx(w) !== 1'b1 || sel_use(w) !== 0) begin
      n_err++;
      $display("FAIL %s idle_after got busy=%0b tx=%0b use=%0d want busy=0 tx=1 use=0",
               name, sel_busy(w), sel_tx(w), sel_use(w));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00);
    repeat (3) step();
    n_vec++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || use1 !== '0 || bus1.data_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dut1 got tx=%0b busy=%0b use=%0d rdy=%0b want 1 0 0 0",
               tx1, busy1, use1, bus1.data_ready_o);
    end
    n_vec++;
    if (tx2 !== 1'b1 || busy2 !== 1'b0 || use2 !== '0 || bus2.data_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dut2 got tx=%0b busy=%0b use=%0d rdy=%0b want 1 0 0 0",
               tx2, busy2, use2, bus2.data_ready_o);
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (bus1.data_ready_o !== 1'b1 || bus2.data_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset got %0b/%0b want 1/1", bus1.data_ready_o, bus2.data_ready_o);
    end
  endtask

  task automatic test_single_byte();
    q_in = '{8'hA5};
    run_stream(0, "single_a5");
  endtask

  task automatic test_back_to_back();
    q_in = '{8'h00, 8'hFF};
    run_stream(0, "back_to_back");
  endtask

  task automatic test_backpressure();
    q_in = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_stream(0, "backpressure");
  endtask

  task automatic test_reset_mid_frame();
    drive(0, 1'b1, 8'h55);
    step();
    drive(0, 1'b0, 8'h00);
    repeat (18) step();
    n_vec++;
    if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL midframe_pre got tx=%0b busy=%0b want tx=0 busy=1", tx1, busy1);
    end
    rst_n = 1'b0;
    step();
    n_vec++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || use1 !== '0 || bus1.data_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_reset got tx=%0b busy=%0b use=%0d rdy=%0b want 1 0 0 0",
               tx1, busy1, use1, bus1.data_ready_o);
    end
    rst_n = 1'b1;
    step();
    q_in = '{8'h3C};
    run_stream(0, "after_reset_3c");
  endtask

  task automatic test_two_stop_bits();
    q_in = '{8'h81, 8'h7E};
    run_stream(1, "stop2");
  endtask

  task automatic test_random_stream();
    q_in.delete();
    for (int i = 0; i < 256; i++) q_in.push_back(8'($urandom_range(0, 255)));
    run_stream(0, "random_256");
    q_in.delete();
    for (int i = 0; i < 16; i++) q_in.push_back(8'($urandom_range(0, 255)));
    run_stream(1, "random_stop2");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_two_stop_bits();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
